// File: rtl/key_step_sequencer.sv
// Purpose: turns three raw push-buttons into clean one-cycle step_up/step_down/step_reset commands.
// Latency: a key held from before edge 1 pulses in the cycle after edge DEBOUNCE_CYCLES+3.
// Backpressure: none; the consumer must take every pulse, and held keys auto-repeat at a fixed rate.
`timescale 1ns/1ps
module key_step_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned REPEAT_DELAY    = 1000,
    parameter int unsigned REPEAT_PERIOD   = 200,
    parameter bit          REPEAT_EN       = 1'b1,
    parameter int unsigned CNT_W           = 32
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_0,
    input  logic key_1,
    input  logic key_2,
    output logic step_up,
    output logic step_down,
    output logic step_reset,
    output logic key_held
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEBOUNCE,
        S_FIRE,
        S_HOLD,
        S_REPEAT,
        S_RELEASE
    } state_t;

    typedef enum logic [1:0] {
        CMD_NONE,
        CMD_UP,
        CMD_DN,
        CMD_RST
    } cmd_t;

    // Terminal counts: every wait state clears the counter on entry and
    // compares for equality, so the counter never has to wrap.
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [2:0]       r_sync1;
    logic [2:0]       r_sync2;
    state_t           r_state;
    state_t           w_state_nxt;
    cmd_t             r_cmd;
    cmd_t             w_cmd_nxt;
    cmd_t             w_dec;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_fired;
    logic             w_fired_nxt;
    logic             r_step_up;
    logic             r_step_down;
    logic             r_step_reset;
    logic             r_key_held;

    // Two-flop synchronisers for the asynchronous key inputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 3'b000;
            r_sync2 <= 3'b000;
        end else begin
            r_sync1 <= {key_2, key_1, key_0};
            r_sync2 <= r_sync1;
        end
    end

    // Key decode: restore wins; UP and DN together cancel to NONE.
    always_comb begin
        w_dec = CMD_NONE;
        if (r_sync2[2]) begin
            w_dec = CMD_RST;
        end else if (r_sync2[0] && !r_sync2[1]) begin
            w_dec = CMD_UP;
        end else if (r_sync2[1] && !r_sync2[0]) begin
            w_dec = CMD_DN;
        end
    end

    // Next-state, latched command, cycle counter and first-fire tracking.
    always_comb begin
        w_state_nxt = r_state;
        w_cmd_nxt   = r_cmd;
        w_cnt_nxt   = r_cnt;
        w_fired_nxt = r_fired;
        case (r_state)
            S_IDLE: begin
                if (w_dec != CMD_NONE) begin
                    w_cmd_nxt   = w_dec;
                    w_cnt_nxt   = '0;
                    w_fired_nxt = 1'b0;
                    w_state_nxt = S_DEBOUNCE;
                end
            end
            S_DEBOUNCE: begin
                if (w_dec != r_cmd) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == DEB_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_FIRE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_FIRE: begin
                // Single pulse cycle; the key is not sampled here.
                w_cnt_nxt   = '0;
                w_fired_nxt = 1'b1;
                if (r_cmd == CMD_RST || !REPEAT_EN) begin
                    w_state_nxt = S_RELEASE;
                end else if (!r_fired) begin
                    w_state_nxt = S_HOLD;
                end else begin
                    w_state_nxt = S_REPEAT;
                end
            end
            S_HOLD: begin
                if (w_dec != r_cmd) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_RELEASE;
                end else if (r_cnt == DLY_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_FIRE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_REPEAT: begin
                if (w_dec != r_cmd) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_RELEASE;
                end else if (r_cnt == PER_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_FIRE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_RELEASE: begin
                // Any key activity restarts the quiet window.
                if (w_dec != CMD_NONE) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == DEB_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register plus outputs registered from the next state so they are glitch-free.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_cmd        <= CMD_NONE;
            r_cnt        <= '0;
            r_fired      <= 1'b0;
            r_step_up    <= 1'b0;
            r_step_down  <= 1'b0;
            r_step_reset <= 1'b0;
            r_key_held   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cmd        <= w_cmd_nxt;
            r_cnt        <= w_cnt_nxt;
            r_fired      <= w_fired_nxt;
            r_step_up    <= (w_state_nxt == S_FIRE) && (w_cmd_nxt == CMD_UP);
            r_step_down  <= (w_state_nxt == S_FIRE) && (w_cmd_nxt == CMD_DN);
            r_step_reset <= (w_state_nxt == S_FIRE) && (w_cmd_nxt == CMD_RST);
            r_key_held   <= (w_state_nxt == S_HOLD) || (w_state_nxt == S_REPEAT);
        end
    end

    assign step_up    = r_step_up;
    assign step_down  = r_step_down;
    assign step_reset = r_step_reset;
    assign key_held   = r_key_held;

endmodule
